div_scheduler: RTL

Round-robin scheduler sharing one fixed-point divider (10-bit Q6.4 operands, start/busy/valid handshake, dvz/ovf flags) among N requesters. It arbitrates pending requests, latches the winner's operands, sequences the divider start pulse, and waits for completion under a watchdog. It routes the quotient and flags back to the winning requester. It sits between the requesting datapath units and the divider instance; the divider is external and connected through the `div_*` ports.

---
 rtl/div_pkg.sv | 23 ++
 rtl/rr_picker.sv | 44 ++++
 rtl/div_scheduler.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the divider scheduler: datapath defaults for the
// Q6.4 fixed-point divider, the default watchdog limit and the scheduler
// state encoding.
// -----------------------------------------------------------------------------
package div_pkg;

    // Operand / quotient width and fraction bits of the Q6.4 format.
    localparam int DIV_W      = 10;
    localparam int DIV_FRAC_W = 4;

    // Cycles allowed from div_start to div_valid before the watchdog fires.
    localparam int DIV_TIMEOUT = 200;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin picker: selects the first active request at or
// after the pointer position, wrapping around modulo N.
//
// Ports
//   req     in  N   request vector
//   ptr     in  PW  search start position
//   gnt     out N   one-hot selection (all zero when nothing requests)
//   idx     out PW  encoded index of the selected requester
//   any_req out 1   at least one request is active
// -----------------------------------------------------------------------------
module rr_picker #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          any_req
);

    always_comb begin
        int j;
        // NOTE: every output gets a default before the loop so no path leaves
        // a variable unassigned, which would otherwise infer a latch.
        gnt     = '0;
        idx     = '0;
        any_req = 1'b0;
        j       = 0;
        // Scan from ptr upward; any_req doubles as the "already found" flag
        // so only the first hit in rotated order is taken.
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!any_req && req[j]) begin
                gnt[j]  = 1'b1;
                idx     = PW'(j);
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/div_scheduler.sv
// -----------------------------------------------------------------------------
// div_scheduler
// Shares one external fixed-point divider among N requesters. A round-robin
// picker selects a pending request, its operands are latched and held on the
// divider inputs, a single start pulse is issued once the divider is free, and
// the result (or a watchdog timeout) is returned to the winning requester.
//
// Ports
//   clk, sclr              clock, synchronous active-high reset
//   req        in  N       level requests
//   a_in, b_in in  N*W     operands, requester i at [i*W +: W]
//   gnt        out N       one-hot grant pulse (operands captured on that edge)
//   rsp_valid  out N       one-hot response pulse
//   rsp_q      out W       quotient, held between responses
//   rsp_dvz/ovf/tmo out 1  divide-by-zero, overflow, watchdog timeout flags
//   div_a, div_b out W     divider operands, stable ISSUE through WAIT
//   div_start  out 1       one-cycle divider start pulse
//   div_q      in  W       divider quotient
//   div_dvz, div_ovf, div_busy, div_valid in 1  divider status
// -----------------------------------------------------------------------------
module div_scheduler
    import div_pkg::*;
#(
    parameter int N       = 4,
    parameter int W       = DIV_W,
    parameter int TIMEOUT = DIV_TIMEOUT
) (
    input  logic           clk,
    input  logic           sclr,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] a_in,
    input  logic [N*W-1:0] b_in,
    output logic [N-1:0]   gnt,
    output logic [N-1:0]   rsp_valid,
    output logic [W-1:0]   rsp_q,
    output logic           rsp_dvz,
    output logic           rsp_ovf,
    output logic           rsp_tmo,
    output logic [W-1:0]   div_a,
    output logic [W-1:0]   div_b,
    output logic           div_start,
    input  logic [W-1:0]   div_q,
    input  logic           div_dvz,
    input  logic           div_ovf,
    input  logic           div_busy,
    input  logic           div_valid
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    state_e        r_state, w_state_next;
    logic [PW-1:0] r_ptr, r_id;
    logic [CW-1:0] r_wdog;
    logic [N-1:0]  r_gnt, r_rsp_valid;
    logic [W-1:0]  r_rsp_q, r_div_a, r_div_b;
    logic          r_rsp_dvz, r_rsp_ovf, r_rsp_tmo, r_div_start;

    logic [N-1:0]  w_pick_gnt;
    logic [PW-1:0] w_pick_idx, w_ptr_next;
    logic          w_pick_any;
    logic [CW-1:0] w_wdog_inc;
    logic          w_expire;
    logic          w_grant, w_issue, w_done_ok, w_done_tmo;

    rr_picker #(.N(N), .PW(PW)) u_picker (
        .req     (req),
        .ptr     (r_ptr),
        .gnt     (w_pick_gnt),
        .idx     (w_pick_idx),
        .any_req (w_pick_any)
    );

    assign w_ptr_next = (w_pick_idx == PW'(N - 1)) ? '0 : w_pick_idx + 1'b1;

    // Saturating watchdog; expiry is judged on the value the counter is
    // about to take, so the response lands exactly TIMEOUT cycles after start.
    assign w_wdog_inc = (&r_wdog) ? r_wdog : r_wdog + 1'b1;
    assign w_expire   = (w_wdog_inc >= CW'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (sclr) r_state <= ST_IDLE;
        else      r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        w_issue      = 1'b0;
        w_done_ok    = 1'b0;
        w_done_tmo   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_any) begin
                    w_grant      = 1'b1;
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // A divider still busy from an abandoned (timed-out) job
                // holds off the next start indefinitely.
                if (!div_busy) begin
                    w_issue      = 1'b1;
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // div_valid wins over a coincident watchdog expiry.
                if (div_valid) begin
                    w_done_ok    = 1'b1;
                    w_state_next = ST_RESP;
                end else if (w_expire) begin
                    w_done_tmo   = 1'b1;
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (sclr) begin
            r_ptr       <= '0;
            r_id        <= '0;
            r_wdog      <= '0;
            r_gnt       <= '0;
            r_rsp_valid <= '0;
            r_rsp_q     <= '0;
            r_rsp_dvz   <= 1'b0;
            r_rsp_ovf   <= 1'b0;
            r_rsp_tmo   <= 1'b0;
            r_div_a     <= '0;
            r_div_b     <= '0;
            r_div_start <= 1'b0;
        end else begin
            r_gnt       <= '0;
            r_rsp_valid <= '0;
            r_div_start <= 1'b0;

            if (w_grant) begin
                r_gnt   <= w_pick_gnt;
                r_id    <= w_pick_idx;
                r_ptr   <= w_ptr_next;
                r_div_a <= a_in[w_pick_idx*W +: W];
                r_div_b <= b_in[w_pick_idx*W +: W];
            end

            if (w_issue) begin
                r_div_start <= 1'b1;
                r_wdog      <= '0;
            end else if (r_state == ST_WAIT) begin
                r_wdog <= w_wdog_inc;
            end

            if (w_done_ok) begin
                r_rsp_valid <= N'(1) << r_id;
                r_rsp_q     <= div_q;
                r_rsp_dvz   <= div_dvz;
                r_rsp_ovf   <= div_ovf;
                r_rsp_tmo   <= 1'b0;
            end else if (w_done_tmo) begin
                r_rsp_valid <= N'(1) << r_id;
                r_rsp_q     <= '0;
                r_rsp_dvz   <= 1'b0;
                r_rsp_ovf   <= 1'b0;
                r_rsp_tmo   <= 1'b1;
            end
        end
    end

    assign gnt       = r_gnt;
    assign rsp_valid = r_rsp_valid;
    assign rsp_q     = r_rsp_q;
    assign rsp_dvz   = r_rsp_dvz;
    assign rsp_ovf   = r_rsp_ovf;
    assign rsp_tmo   = r_rsp_tmo;
    assign div_a     = r_div_a;
    assign div_b     = r_div_b;
    assign div_start = r_div_start;

endmodule
